// File: rtl/sap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sap_ctrl_pkg
// Shared constants for the SAP-BR control path: control-word and ROM address
// widths, control-word bit positions decoded by the sequencer, the opcodes the
// sequencer cares about, and the default T-state configuration.
// -----------------------------------------------------------------------------
package sap_ctrl_pkg;

    localparam int CW_WIDTH     = 18;
    localparam int ADDR_WIDTH   = 7;
    localparam int OPCODE_WIDTH = 4;
    localparam int STEP_WIDTH   = 3;
    localparam int IR_WIDTH     = 8;

    // Control-word bit positions.
    localparam int CW_HLT    = 17;
    localparam int CW_IR_IN  = 10;
    localparam int CW_IR_OUT = 9;

    // Default T-state configuration.
    localparam int DEF_STEPS         = 5;
    localparam int DEF_MIN_SKIP_STEP = 2;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_NOP = 4'b0000,
        OP_HLT = 4'b1111
    } opcode_e;

    typedef logic [CW_WIDTH-1:0] cw_t;

endpackage

// File: rtl/step_debounce_sync.sv
// -----------------------------------------------------------------------------
// step_debounce_sync
// Brings an asynchronous front-panel level into the clk domain with a 2-flop
// synchroniser and emits a single-cycle pulse on its rising edge. Holding the
// input high yields exactly one pulse.
//
// Ports:
//   clk_i    in   system clock, rising edge
//   rst_i    in   asynchronous active-high reset
//   level_i  in   asynchronous button level
//   pulse_o  out  one-cycle pulse, two to three cycles after level_i rises
// -----------------------------------------------------------------------------
module step_debounce_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic pulse_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, giving a true two-stage shift.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], level_i};
            prev_q <= sync_q[1];
        end
    end

    assign pulse_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Instruction register plus T-state counter forming the microcode ROM address
// {opcode, step}. Decodes the returned control word to load the IR, end an
// instruction early on an all-zero word, and halt. Supports free-run and
// single-step operation.
//
// Ports:
//   CLK           in   system clock, rising edge
//   CLR           in   asynchronous active-high reset
//   Run           in   1 = free-run, 0 = single-step
//   Step_Btn      in   asynchronous single-step request (level)
//   Bus    [7:0]  in   data bus, IR load source
//   Control_Word  in   18-bit word from the ROM for the current Address
//   Address [6:0] out  ROM address {IR[7:4], Step}
//   Opcode  [3:0] out  IR[7:4]
//   Operand_Out   out  IR[3:0] while the IR-out bit is set, else 0
//   Operand_En    out  IR-out control bit
//   Step    [2:0] out  current T-state
//   T             out  one-hot T-state for display
//   Halted        out  sticky halt flag
// -----------------------------------------------------------------------------
module control_sequencer
    import sap_ctrl_pkg::*;
#(
    parameter int STEPS         = DEF_STEPS,          // must not exceed 8
    parameter int HLT_BIT       = CW_HLT,
    parameter int IR_IN_BIT     = CW_IR_IN,
    parameter int IR_OUT_BIT    = CW_IR_OUT,
    parameter int MIN_SKIP_STEP = DEF_MIN_SKIP_STEP
) (
    input  logic                    CLK,
    input  logic                    CLR,
    input  logic                    Run,
    input  logic                    Step_Btn,
    input  logic [IR_WIDTH-1:0]     Bus,
    input  logic [CW_WIDTH-1:0]     Control_Word,
    output logic [ADDR_WIDTH-1:0]   Address,
    output logic [OPCODE_WIDTH-1:0] Opcode,
    output logic [3:0]              Operand_Out,
    output logic                    Operand_En,
    output logic [STEP_WIDTH-1:0]   Step,
    output logic [STEPS-1:0]        T,
    output logic                    Halted
);

    localparam logic [STEP_WIDTH-1:0] STEP_LAST = STEP_WIDTH'(STEPS - 1);
    localparam logic [STEP_WIDTH-1:0] STEP_SKIP = STEP_WIDTH'(MIN_SKIP_STEP);
    localparam logic [STEPS-1:0]      T_ONE     = {{(STEPS-1){1'b0}}, 1'b1};

    logic [IR_WIDTH-1:0]   ir_q,     ir_d;
    logic [STEP_WIDTH-1:0] step_q,   step_d;
    logic                  halted_q, halted_d;
    logic                  step_pulse;
    logic                  adv;

    step_debounce_sync u_step_sync (
        .clk_i   (CLK),
        .rst_i   (CLR),
        .level_i (Step_Btn),
        .pulse_o (step_pulse)
    );

    // Run overrides the button; a halt freezes everything until CLR.
    assign adv = ~halted_q & (Run | step_pulse);

    // State register.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            ir_q     <= '0;
            step_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every variable gets a hold value first so no path through
        // the branches below leaves it unassigned and infers a latch.
        ir_d     = ir_q;
        step_d   = step_q;
        halted_d = halted_q;

        if (adv) begin
            if (Control_Word[HLT_BIT]) begin
                // Halt wins over an IR load in the same word; Step holds.
                halted_d = 1'b1;
            end else begin
                if (step_q == STEP_LAST) begin
                    step_d = '0;
                end else if (step_q >= STEP_SKIP && Control_Word == '0) begin
                    // Remaining steps of this instruction do nothing.
                    step_d = '0;
                end else begin
                    step_d = step_q + 1'b1;
                end

                if (Control_Word[IR_IN_BIT]) begin
                    ir_d = Bus;
                end
            end
        end
    end

    // Output logic.
    always_comb begin
        Address     = {ir_q[7:4], step_q};
        Opcode      = ir_q[7:4];
        Operand_En  = Control_Word[IR_OUT_BIT];
        Operand_Out = Control_Word[IR_OUT_BIT] ? ir_q[3:0] : 4'b0000;
        Step        = step_q;
        T           = T_ONE << step_q;
        Halted      = halted_q;
    end

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
// Directed bench for control_sequencer: reset, fetch/IR load, wrap, early end,
// halt, run toggling and single-step.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

    localparam logic [17:0] CW_NZ     = 18'h00001;
    localparam logic [17:0] CW_IR_IN  = 18'h00400;
    localparam logic [17:0] CW_IR_OUT = 18'h00200;
    localparam logic [17:0] CW_HALT   = 18'h20000;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        Run;
    logic        Step_Btn;
    logic [7:0]  Bus;
    logic [17:0] Control_Word;
    logic [6:0]  Address;
    logic [3:0]  Opcode;
    logic [3:0]  Operand_Out;
    logic        Operand_En;
    logic [2:0]  Step;
    logic [4:0]  T;
    logic        Halted;

    int n_cmp = 0;
    int n_bad = 0;

    control_sequencer dut (
        .CLK          (CLK),
        .CLR          (CLR),
        .Run          (Run),
        .Step_Btn     (Step_Btn),
        .Bus          (Bus),
        .Control_Word (Control_Word),
        .Address      (Address),
        .Opcode       (Opcode),
        .Operand_Out  (Operand_Out),
        .Operand_En   (Operand_En),
        .Step         (Step),
        .T            (T),
        .Halted       (Halted)
    );

    always #5 CLK = ~CLK;

    // Advance one edge and settle 1 ns past it.
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Short CLR pulse placed between edges.
    task automatic do_reset;
        CLR = 1'b1;
        #2;
        CLR = 1'b0;
    endtask

    task automatic test_reset;
        // Power-on reset held across edges.
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++;
        if (Address !== 7'b0000000) begin
            $display("FAIL por_address: got %b expected %b", Address, 7'b0000000);
            n_bad++;
        end
        n_cmp++;
        if (T !== 5'b00001) begin
            $display("FAIL por_T: got %b expected %b", T, 5'b00001);
            n_bad++;
        end
        CLR = 1'b0;

        // Build up non-zero state, then reset mid-cycle.
        Run = 1'b1; Control_Word = CW_IR_IN; Bus = 8'hA5;
        tick;
        tick;
        n_cmp++;
        if (Address !== 7'b1010010) begin
            $display("FAIL pre_clr_address: got %b expected %b", Address, 7'b1010010);
            n_bad++;
        end
        @(posedge CLK);
        #3;
        CLR = 1'b1;
        #1;
        n_cmp++;
        if (Address !== 7'b0000000) begin
            $display("FAIL async_clr_address: got %b expected %b", Address, 7'b0000000);
            n_bad++;
        end
        n_cmp++;
        if (T !== 5'b00001) begin
            $display("FAIL async_clr_T: got %b expected %b", T, 5'b00001);
            n_bad++;
        end
        n_cmp++;
        if (Halted !== 1'b0) begin
            $display("FAIL async_clr_halted: got %b expected %b", Halted, 1'b0);
            n_bad++;
        end
        #1;
        CLR = 1'b0;
        Control_Word = CW_NZ;
        tick;
        n_cmp++;
        if (Step !== 3'd1) begin
            $display("FAIL post_clr_first_step: got %0d expected %0d", Step, 1);
            n_bad++;
        end
    endtask

    task automatic test_fetch;
        do_reset;
        Run = 1'b1; Control_Word = CW_NZ; Bus = 8'h00;
        tick;
        n_cmp++;
        if (Address !== 7'b0000001) begin
            $display("FAIL fetch_step1_address: got %b expected %b", Address, 7'b0000001);
            n_bad++;
        end
        Control_Word = CW_IR_IN; Bus = 8'h1E;
        tick;
        n_cmp++;
        if (Opcode !== 4'b0001) begin
            $display("FAIL fetch_opcode: got %b expected %b", Opcode, 4'b0001);
            n_bad++;
        end
        n_cmp++;
        if (Address !== 7'b0001010) begin
            $display("FAIL fetch_address: got %b expected %b", Address, 7'b0001010);
            n_bad++;
        end
        Control_Word = CW_IR_OUT;
        #1;
        n_cmp++;
        if (Operand_Out !== 4'hE || Operand_En !== 1'b1) begin
            $display("FAIL operand_on: got %h/%b expected %h/%b", Operand_Out, Operand_En, 4'hE, 1'b1);
            n_bad++;
        end
        Control_Word = CW_NZ;
        #1;
        n_cmp++;
        if (Operand_Out !== 4'h0 || Operand_En !== 1'b0) begin
            $display("FAIL operand_off: got %h/%b expected %h/%b", Operand_Out, Operand_En, 4'h0, 1'b0);
            n_bad++;
        end
    endtask

    task automatic test_wrap;
        logic [2:0] exp_step [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        logic [4:0] exp_t    [5] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        do_reset;
        Run = 1'b1; Control_Word = CW_NZ;
        n_cmp++;
        if (Step !== 3'd0 || T !== 5'b00001) begin
            $display("FAIL wrap_start: got %0d/%b expected 0/00001", Step, T);
            n_bad++;
        end
        for (int i = 0; i < 5; i++) begin
            tick;
            n_cmp++;
            if (Step !== exp_step[i] || T !== exp_t[i]) begin
                $display("FAIL wrap_%0d: got %0d/%b expected %0d/%b", i, Step, T, exp_step[i], exp_t[i]);
                n_bad++;
            end
        end
    endtask

    task automatic test_early_end;
        do_reset;
        Run = 1'b1; Control_Word = CW_NZ;
        tick;
        Control_Word = 18'h0;
        tick;
        n_cmp++;
        if (Step !== 3'd2) begin
            $display("FAIL zero_at_step1: got %0d expected %0d", Step, 2);
            n_bad++;
        end
        tick;
        n_cmp++;
        if (Step !== 3'd0) begin
            $display("FAIL zero_at_step2: got %0d expected %0d", Step, 0);
            n_bad++;
        end
        Control_Word = CW_NZ;
        repeat (3) tick;
        Control_Word = 18'h0;
        tick;
        n_cmp++;
        if (Step !== 3'd0) begin
            $display("FAIL zero_at_step3: got %0d expected %0d", Step, 0);
            n_bad++;
        end
    endtask

    task automatic test_halt;
        logic [17:0] cw_tab [3] = '{CW_NZ, CW_HALT | CW_IR_IN, CW_IR_IN};
        do_reset;
        Run = 1'b1; Control_Word = CW_NZ;
        tick;
        Control_Word = CW_IR_IN; Bus = 8'hF0;
        tick;
        n_cmp++;
        if (Opcode !== 4'b1111 || Step !== 3'd2) begin
            $display("FAIL halt_setup: got %b/%0d expected 1111/2", Opcode, Step);
            n_bad++;
        end
        // Halt and IR load together: halt wins, Bus value must not land.
        Control_Word = CW_HALT | CW_IR_IN; Bus = 8'h33;
        tick;
        n_cmp++;
        if (Halted !== 1'b1 || Step !== 3'd2 || Opcode !== 4'b1111) begin
            $display("FAIL halt_entry: got %b/%0d/%b expected 1/2/1111", Halted, Step, Opcode);
            n_bad++;
        end
        for (int i = 0; i < 20; i++) begin
            Bus = 8'(i * 17 + 3);
            Control_Word = cw_tab[i % 3];
            tick;
            n_cmp++;
            if (Address !== 7'b1111010 || Halted !== 1'b1) begin
                $display("FAIL halt_hold_%0d: got %b/%b expected 1111010/1", i, Address, Halted);
                n_bad++;
            end
        end
        do_reset;
        n_cmp++;
        if (Halted !== 1'b0 || Address !== 7'b0000000) begin
            $display("FAIL halt_clear: got %b/%b expected 0/0000000", Halted, Address);
            n_bad++;
        end
    endtask

    task automatic test_run_toggle;
        do_reset;
        Run = 1'b1; Control_Word = CW_NZ;
        tick;
        tick;
        Run = 1'b0;
        repeat (3) tick;
        n_cmp++;
        if (Step !== 3'd2) begin
            $display("FAIL run_off_hold: got %0d expected %0d", Step, 2);
            n_bad++;
        end
        Run = 1'b1;
        tick;
        n_cmp++;
        if (Step !== 3'd3) begin
            $display("FAIL run_resume: got %0d expected %0d", Step, 3);
            n_bad++;
        end
    endtask

    task automatic test_single_step;
        logic [2:0] prev;
        int adv_cnt;
        int first;
        do_reset;
        Run = 1'b0; Step_Btn = 1'b0; Control_Word = CW_NZ;
        repeat (3) tick;
        n_cmp++;
        if (Step !== 3'd0) begin
            $display("FAIL ss_idle: got %0d expected %0d", Step, 0);
            n_bad++;
        end

        for (int press = 0; press < 2; press++) begin
            prev = Step; adv_cnt = 0; first = -1;
            Step_Btn = 1'b1;
            for (int c = 1; c <= 10; c++) begin
                tick;
                if (Step !== prev) begin
                    adv_cnt++;
                    if (first < 0) first = c;
                    prev = Step;
                end
            end
            n_cmp++;
            if (adv_cnt != 1) begin
                $display("FAIL ss_count_%0d: got %0d advances expected %0d", press, adv_cnt, 1);
                n_bad++;
            end
            n_cmp++;
            if (first != 3) begin
                $display("FAIL ss_latency_%0d: got cycle %0d expected %0d", press, first, 3);
                n_bad++;
            end
            n_cmp++;
            if (Step !== 3'(press + 1)) begin
                $display("FAIL ss_step_%0d: got %0d expected %0d", press, Step, press + 1);
                n_bad++;
            end
            Step_Btn = 1'b0;
            repeat (4) tick;
        end
        n_cmp++;
        if (Step !== 3'd2) begin
            $display("FAIL ss_release_hold: got %0d expected %0d", Step, 2);
            n_bad++;
        end
    endtask

    initial begin
        CLR = 1'b1; Run = 1'b0; Step_Btn = 1'b0; Bus = 8'h00; Control_Word = 18'h0;
        test_reset;
        test_fetch;
        test_wrap;
        test_early_end;
        test_halt;
        test_run_toggle;
        test_single_step;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Instruction register plus T-state step counter that drives the 7-bit microcode ROM address {opcode[3:0], step[2:0]}. It consumes the ROM's 18-bit control word to load the IR, to end an instruction early and to halt. It provides run/single-step clocking control for the SAP-BR datapath.

Parameters:
STEPS, 5, T-states per instruction (steps 0..STEPS-1); must be ≤ 8.
HLT_BIT, 17, control-word bit that halts the sequencer.
IR_IN_BIT, 10, control-word bit that loads the IR from Bus.
IR_OUT_BIT, 9, control-word bit that drives the IR operand onto the bus.
MIN_SKIP_STEP, 2, first step at which an all-zero control word ends the instruction.

Ports:
CLK  in  1  system clock, rising edge.
CLR  in  1  reset, asynchronous, active-high.
Run  in  1  1 = free-run; 0 = single-step mode.
Step_Btn  in  1  asynchronous single-step request, level.
Bus  in  8  data bus; source for IR load.
Control_Word  in  18  control word from the microcode ROM for the current Address.
Address  out  7  ROM address = {IR[7:4], Step}.
Opcode  out  4  IR[7:4].
Operand_Out  out  4  IR[3:0] when the IR_OUT_BIT control bit is set, else 0.
Operand_En  out  1  equals Control_Word[IR_OUT_BIT].
Step  out  3  current T-state.
T  out  STEPS  one-hot T-state for display.
Halted  out  1  sticky halt flag.

Behaviour:
- Reset (CLR=1, async): IR=0, Step=0, T=00001, Halted=0, step synchroniser and edge detector cleared. Address is 0000000 after reset. CLR dominates every other input in every cycle.
- Advance enable: adv = ~Halted & (Run | step_pulse).
  - step_pulse is a one-cycle pulse produced by a 2-flop synchroniser plus rising-edge detect on Step_Btn.
  - Holding Step_Btn high produces exactly one pulse.
  - In Run=1, step_pulse is ignored.
- On the rising CLK edge with adv=1:
  - If Control_Word[HLT_BIT]=1: Halted←1, Step unchanged. Halted blocks all further advance and IR loads until CLR.
  - Else if Step==STEPS-1: Step←0 (wrap).
  - Else if Step≥MIN_SKIP_STEP and Control_Word==0: Step←0 (early end; dead steps skipped).
  - Else Step←Step+1.
  - IR loads from Bus when Control_Word[IR_IN_BIT]=1, on the same edge as the step update. The next Address uses the new opcode together with the new Step.
- With adv=0, all state holds and the outputs stay stable. Combinational outputs still follow Control_Word.
- Latency: Address changes one CLK after the advancing edge. The ROM is combinational, so a control word is valid within the same cycle.
- Step is never driven ≥ STEPS. Steps 5..7 are never addressed.
- A HLT and an IR load in the same control word: halt takes priority and the IR does not load.
- Run toggling mid-instruction: takes effect on the next edge; Step is preserved.
- CLR mid-instruction: immediately returns to fetch step 0 with IR=0.

Decomposition:
- Shared package sap_ctrl_pkg: CW_WIDTH=18, ADDR_WIDTH=7, OPCODE_WIDTH=4, the control-bit index constants (HLT, IR_IN, IR_OUT), and opcode constants (NOP=0000, HLT=1111).
- One natural sub-module: step_debounce_sync (2-flop synchroniser plus rising-edge pulse for Step_Btn), reusable for other front-panel inputs.

Test Plan:
- Reset: CLR pulse asynchronously mid-cycle → Address=0000000, T=00001, Halted=0 before the next CLK edge.
- Fetch/IR load: Run=1, Bus=8'h1E, Control_Word with bit 10 set at step 1 → after the edge, Opcode=0001 and Address=0001010.
- Wrap: five consecutive non-zero words → Step sequence 0,1,2,3,4,0 and T rotates 00001→10000→00001.
- Early end: Control_Word=0 at step 2 → next Step=0. Control_Word=0 at step 1 → next Step=2 (no skip).
- Halt: Opcode=1111 at step 2, Control_Word bit17=1 → Halted=1, Step stays 2 for 20 cycles, Bus changes ignored. CLR clears it.
- Single-step: Run=0, Step_Btn held high for 10 cycles → Step advances exactly once, about 3 cycles after assertion. A second press advances it once more.
